// File: rtl/piso_pkg.sv
//------------------------------------------------------------------------------
// Module  : piso_pkg
// Brief   : Shared state encoding, default width and shift-order constants
//           for the parallel-in / serial-out serializer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package piso_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   localparam int   DEFAULT_MSB   = 4;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/piso_bit_cnt.sv
//------------------------------------------------------------------------------
// Module  : piso_bit_cnt
// Brief   : Down-counter tracking the bits left in the word being serialized.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_bit_cnt
   import piso_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   // Load has priority; the counter saturates at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign count = r_count;
   assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
//------------------------------------------------------------------------------
// Module  : piso_serializer
// Brief   : Parallel-in / serial-out serializer with ready/valid load, shift
//           enable, selectable bit order and back-to-back word support.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_serializer
   import piso_pkg::*;
#(
   parameter int MSB = DEFAULT_MSB
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic [MSB-1:0] load_data,
   input  logic           dir,
   input  logic           en,
   output logic           sout,
   output logic           sout_valid,
   output logic           last
);

   localparam int             c_cnt_w    = (MSB > 1) ? $clog2(MSB) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MSB - 1);

   piso_state_t        r_state;
   piso_state_t        w_state_nxt;
   logic [MSB-1:0]     r_sreg;
   logic               r_dir;
   logic               r_rdy_en;
   logic [c_cnt_w-1:0] w_cnt;
   logic               w_zero;
   logic               w_xfer;
   logic               w_shift;
   logic               w_load_ready;
   logic               w_sout_valid;
   logic               w_last;

   // Holds load_ready low until the first edge after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load_ready = 1'b0;
      w_sout_valid = 1'b0;
      w_last       = 1'b0;
      w_xfer       = 1'b0;
      w_shift      = 1'b0;
      case (r_state)
         IDLE: begin
            w_load_ready = r_rdy_en;
         end
         SHIFT: begin
            w_sout_valid = 1'b1;
            w_last       = w_zero;
            w_load_ready = r_rdy_en & w_zero & en;
            w_shift      = en & ~w_zero;
            if (w_zero && en && !load_valid) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_xfer = load_valid & w_load_ready;
      if (w_xfer) begin
         w_state_nxt = SHIFT;
      end
   end

   // The bit on sout always sits at the end of the register selected by r_dir
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sreg <= '0;
         r_dir  <= DIR_LSB_FIRST;
      end else if (w_xfer) begin
         r_sreg <= load_data;
         r_dir  <= dir;
      end else if (w_shift) begin
         if (r_dir == DIR_MSB_FIRST) begin
            r_sreg <= {r_sreg[MSB-2:0], 1'b0};
         end else begin
            r_sreg <= {1'b0, r_sreg[MSB-1:1]};
         end
      end
   end

   piso_bit_cnt #(
      .WIDTH (c_cnt_w)
   ) u_bit_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (w_xfer),
      .dec      (w_shift),
      .load_val (c_cnt_init),
      .count    (w_cnt),
      .zero     (w_zero)
   );

   assign load_ready = w_load_ready;
   assign sout_valid = w_sout_valid;
   assign last       = w_last;
   assign sout       = (r_state == SHIFT) ?
                       ((r_dir == DIR_MSB_FIRST) ? r_sreg[MSB-1] : r_sreg[0]) : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
//------------------------------------------------------------------------------
// Module  : tb_piso_serializer
// Brief   : Self-checking bench: queue-based bit-stream model plus directed
//           literal sequences and randomized traffic.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_serializer;

   localparam int MSB = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           load_valid = 1'b0;
   logic           load_ready;
   logic [MSB-1:0] load_data = '0;
   logic           dir = 1'b0;
   logic           en = 1'b0;
   logic           sout;
   logic           sout_valid;
   logic           last;

   int total = 0;
   int bad   = 0;

   piso_serializer #(.MSB(MSB)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .dir        (dir),
      .en         (en),
      .sout       (sout),
      .sout_valid (sout_valid),
      .last       (last)
   );

   always #5 clk = ~clk;

   // Model: the remaining bits of the word in flight, in emission order
   bit mq[$];
   bit m_rdy_en = 1'b0;

   function automatic bit m_ready();
      return m_rdy_en && ((mq.size() == 0) || ((mq.size() == 1) && en));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_rdy_en = 1'b0;
      end else begin
         if (load_valid && m_ready()) begin
            mq.delete();
            for (int i = 0; i < MSB; i++)
               mq.push_back(dir ? load_data[MSB-1-i] : load_data[i]);
         end else if ((mq.size() > 0) && en) begin
            void'(mq.pop_front());
         end
         m_rdy_en = 1'b1;
      end
   end

   task automatic chk(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b expected=%b at t=%0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("mdl_valid", sout_valid, mq.size() > 0);
      chk("mdl_sout",  sout,       (mq.size() > 0) ? mq[0] : 1'b0);
      chk("mdl_last",  last,       mq.size() == 1);
      chk("mdl_ready", load_ready, m_ready());
   end

   // Apply inputs just after an edge, then return at the following negedge
   task automatic cyc(input logic lv, input logic [MSB-1:0] d, input logic dr, input logic e);
      @(posedge clk);
      #2;
      load_valid = lv;
      load_data  = d;
      dir        = dr;
      en         = e;
      @(negedge clk);
   endtask

   initial begin : main
      logic [MSB-1:0] w;
      logic [5:0]     en_pat;
      logic [5:0]     exp32;
      logic [7:0]     exp33;

      #1;
      chk("rst_ready", load_ready, 1'b0);
      chk("rst_valid", sout_valid, 1'b0);
      chk("rst_sout",  sout,       1'b0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("prerelease_ready", load_ready, 1'b0);
      cyc(0, '0, 0, 1);
      chk("idle_ready", load_ready, 1'b1);

      // 1011 LSB first, then MSB first
      w = 4'b1011;
      for (int d = 0; d < 2; d++) begin
         cyc(1, w, d[0], 1);
         for (int i = 0; i < MSB; i++) begin
            cyc(0, 4'b0000, ~d[0], 1);
            chk("dir_sout",  sout, (d == 0) ? w[i] : w[MSB-1-i]);
            chk("dir_last",  last, i == MSB - 1);
            chk("dir_valid", sout_valid, 1'b1);
         end
         cyc(0, '0, 0, 1);
         chk("dir_idle", sout_valid, 1'b0);
      end

      // en gaps: 0110, en = 1,0,0,1,1,1 -> 0,0,0,1,1,0
      en_pat = 6'b111001;
      exp32  = 6'b011000;
      cyc(1, 4'b0110, 0, en_pat[0]);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 4'b1111, 1, (i < 5) ? en_pat[i+1] : 1'b1);
         chk("gap_sout", sout, exp32[i]);
         chk("gap_last", last, i >= 5);
      end
      cyc(0, '0, 0, 1);

      // back-to-back: 0001 then 1000 -> 1,0,0,0,0,0,0,1
      exp33 = 8'b1000_0001;
      cyc(1, 4'b0001, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(i < 4, 4'b1000, 0, 1);
         chk("b2b_valid", sout_valid, 1'b1);
         chk("b2b_sout",  sout, exp33[i]);
         chk("b2b_ready", load_ready, (i == 3) || (i == 7));
      end
      cyc(0, '0, 0, 1);
      chk("b2b_idle", sout_valid, 1'b0);

      // async reset after the 2nd bit of 1111
      cyc(1, 4'b1111, 0, 1);
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_sout",  sout,       1'b0);
      chk("arst_valid", sout_valid, 1'b0);
      chk("arst_ready", load_ready, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 0, 1);
         chk("arst_nobits", sout_valid, 1'b0);
      end
      chk("arst_ready_after", load_ready, 1'b1);

      // load offered mid-word is ignored: 1100 LSB first -> 0,0,1,1
      w = 4'b1100;
      cyc(1, w, 0, 1);
      for (int i = 0; i < MSB; i++) begin
         cyc(i == 1, 4'b0101, 1, 1);
         chk("ign_sout", sout, w[i]);
      end
      cyc(0, '0, 0, 1);
      chk("ign_idle", sout_valid, 1'b0);

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 2) != 0, MSB'($urandom), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0);
      end
      cyc(0, '0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter MSB, default 4, is the serial word width in bits; legal values are 2 to 32.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port load_valid, input, 1 bit: a parallel word is offered on load_data.
REQ-005 Port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-006 Port load_data, input, MSB bits: the parallel word to serialize.
REQ-007 Port dir, input, 1 bit: shift order, sampled only at load; 0 = bit 0 first, 1 = bit MSB-1 first.
REQ-008 Port en, input, 1 bit: shift enable; when 0, the serial output holds.
REQ-009 Port sout, output, 1 bit: the current serial bit.
REQ-010 Port sout_valid, output, 1 bit: sout carries a valid data bit.
REQ-011 Port last, output, 1 bit: sout is the final bit of the current word.

Function
REQ-012 The block SHALL implement states IDLE and SHIFT.
REQ-013 In IDLE, load_ready=1, sout_valid=0, last=0 and sout=0.
REQ-014 IDLE -> SHIFT when load_valid=1 and load_ready=1 at a clk edge (a transfer).
- On that edge the block captures load_data into an MSB-bit shift register, captures dir, and sets the bit counter to MSB-1.
REQ-015 From the edge following a transfer, sout_valid=1 and sout shows the first bit.
- First bit is load_data[0] if the captured dir=0, load_data[MSB-1] if the captured dir=1.
- Latency from transfer edge to first valid bit: 0 cycles after the edge (registered output).
REQ-016 In SHIFT with en=1, each edge advances sout to the next bit in the captured order and decrements the counter.
REQ-017 In SHIFT with en=0, sout, sout_valid, last, the register and the counter SHALL hold.
REQ-018 last=1 exactly while in SHIFT with counter=0.
REQ-019 In SHIFT, load_ready=1 only when last=1 and en=1; otherwise load_ready=0.
REQ-020 End of the final bit (edge with last=1 and en=1):
- If load_valid=1, the new word is captured and the block stays in SHIFT with no idle gap.
- Otherwise the block returns to IDLE.
REQ-021 load_valid while load_ready=0 SHALL be ignored: no capture and no change to the word in flight.
REQ-022 A change on dir or load_data during SHIFT SHALL NOT affect the word in flight.
REQ-023 Every word SHALL produce exactly MSB valid bits on sout, each qualified by an en=1 edge.
- No bit is dropped or duplicated across en gaps or back-to-back words.

Reset
REQ-024 While rst=1, asynchronously:
- state=IDLE, counter=0, shift register=0;
- outputs sout=0, sout_valid=0, last=0, load_ready=0.
REQ-025 After rst deasserts, load_ready=1 from the first edge.
REQ-026 Reset during SHIFT SHALL abort the word; no remaining bits are emitted after reset release.

Structure
REQ-027 A package piso_pkg SHALL hold:
- the state enum (IDLE, SHIFT);
- the default width constant (4);
- the dir encoding constants (DIR_LSB_FIRST=0, DIR_MSB_FIRST=1).
REQ-028 The bit counter SHALL be a sub-module piso_bit_cnt.
- Ports: load, dec, load value; outputs count and zero flag.
- Width: clog2(MSB) bits.
REQ-029 The RTL SHALL be synthesizable, with no latches and one clock domain.

Verification
REQ-030 MSB=4, rst released, load 4'b1011 with dir=0 and en held 1 -> sout=1,1,0,1 on four consecutive cycles; last=1 only on the 4th; then IDLE.
REQ-031 Same word with dir=1 -> sout=1,0,1,1; last on the 4th bit; sout_valid=1 for exactly 4 cycles.
REQ-032 Load 4'b0110 with dir=0, en=1,0,0,1,1,1 -> sout sequence 0,0,0,1,1,0.
- The first bit holds for 3 cycles; last holds through gaps.
REQ-033 Back-to-back words:
- Stimulus: load_valid held high with 4'b0001 then 4'b1000, dir=0.
- Response: 8 contiguous valid bits 1,0,0,0,0,0,0,1; load_ready pulses on each last cycle; no idle cycle.
REQ-034 Assert rst after the 2nd bit of 4'b1111 -> sout=0, sout_valid=0 and load_ready=0 immediately.
- After release: load_ready=1 and no further bits appear.
REQ-035 load_valid=1 with 4'b0101 during the 2nd bit of an in-flight word -> ignored; the in-flight word's bits are unchanged.
